id_ex_stage: RTL and testbench

- ID/EX pipeline register plus operand forwarding and load-use hazard detection for the 5-stage RV32I pipeline.
- Captures decoded operands and control from the decode stage.
- Drives the execute-stage ALU inputs (rs1/rs2 data, imm32, ALUSrc, ALUOp, funct3, funct7) with forwarded values.
- Issues the stall and bubble decisions for the front end.

---
 rtl/id_ex_stage.sv | 152 +++++++++++++++
 tb/tb_id_ex_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use hazard detection
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm32,
  input  logic             id_alu_src,
  input  logic [1:0]       id_alu_op,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_branch,
  input  logic             flush,
  input  logic             hold,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [XLEN-1:0]  mem_result,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic [XLEN-1:0]  wb_data,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_fwd,
  output logic [XLEN-1:0]  ex_rs2_fwd,
  output logic [XLEN-1:0]  ex_imm32,
  output logic             ex_alu_src,
  output logic [1:0]       ex_alu_op,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_branch,
  output logic [CNT_W-1:0] bubble_count
);

  // Source register indices and operand values held for the EX slot
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;

  logic            luh;
  logic [XLEN-1:0] rs1_cap;
  logic [XLEN-1:0] rs2_cap;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A load in EX whose destination the decode instruction reads cannot be forwarded in time
  assign luh = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // A flush kills the dependent instruction anyway, and a hold already freezes the front end
  assign stall_id = luh & ~flush & ~hold;

  // Register file is written in the same cycle it is read, so take the write-back value directly
  assign rs1_cap = (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
  assign rs2_cap = (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;

  // Pipeline register update: hold > flush > load-use bubble > normal capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rs1        <= 5'd0;
      ex_rs2        <= 5'd0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm32      <= '0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= 2'd0;
      ex_funct3     <= 3'd0;
      ex_funct7     <= 7'd0;
      ex_rd         <= 5'd0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      bubble_count  <= '0;
    end else if (hold) begin
      // everything frozen; a pending flush or hazard is seen again next cycle
    end else if (flush || luh) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      if (!flush && (bubble_count != CNT_MAX)) begin
        bubble_count <= bubble_count + CNT_ONE;
      end
    end else begin
      ex_valid      <= id_valid;
      ex_pc         <= id_pc;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rs1_data   <= rs1_cap;
      ex_rs2_data   <= rs2_cap;
      ex_imm32      <= id_imm32;
      ex_alu_src    <= id_alu_src;
      ex_alu_op     <= id_alu_op;
      ex_funct3     <= id_funct3;
      ex_funct7     <= id_funct7;
      ex_rd         <= id_rd;
      ex_reg_write  <= id_valid & id_reg_write;
      ex_mem_read   <= id_valid & id_mem_read;
      ex_mem_write  <= id_valid & id_mem_write;
      ex_mem_to_reg <= id_valid & id_mem_to_reg;
      ex_branch     <= id_valid & id_branch;
    end
  end

  // Operand forwarding: x0 never forwarded, EX/MEM result is newer than MEM/WB
  always_comb begin
    ex_rs1_fwd = ex_rs1_data;
    if (ex_rs1 != 5'd0) begin
      if (mem_reg_write && (mem_rd == ex_rs1)) begin
        ex_rs1_fwd = mem_result;
      end else if (wb_reg_write && (wb_rd == ex_rs1)) begin
        ex_rs1_fwd = wb_data;
      end
    end
    ex_rs2_fwd = ex_rs2_data;
    if (ex_rs2 != 5'd0) begin
      if (mem_reg_write && (mem_rd == ex_rs2)) begin
        ex_rs2_fwd = mem_result;
      end else if (wb_reg_write && (wb_rd == ex_rs2)) begin
        ex_rs2_fwd = wb_data;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm32;
  logic        id_alu_src;
  logic [1:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic        flush, hold;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [31:0] mem_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        stall_id, ex_valid;
  logic [31:0] ex_pc, ex_rs1_fwd, ex_rs2_fwd, ex_imm32;
  logic        ex_alu_src;
  logic [1:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic [15:0] bubble_count;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm32(id_imm32),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .flush(flush), .hold(hold),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_fwd(ex_rs1_fwd), .ex_rs2_fwd(ex_rs2_fwd), .ex_imm32(ex_imm32),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .bubble_count(bubble_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm32 = 0;
    id_alu_src = 0; id_alu_op = 0; id_funct3 = 0; id_funct7 = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
    flush = 0; hold = 0;
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_data = 0;
  endtask

  task automatic load_lw_x7();
    idle_inputs();
    id_valid = 1; id_pc = 32'h20; id_rd = 7; id_rs1 = 2; id_use_rs1 = 1;
    id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; id_imm32 = 32'h4;
  endtask

  task automatic add_x8_x7_x1();
    idle_inputs();
    id_valid = 1; id_pc = 32'h24; id_rd = 8; id_rs1 = 7; id_rs2 = 1;
    id_use_rs1 = 1; id_use_rs2 = 1; id_rs1_data = 32'h700; id_rs2_data = 32'h10;
    id_reg_write = 1;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    #3;
    check("reset_valid", 32'(ex_valid), 32'h0);
    check("reset_pc", ex_pc, 32'h0);
    check("reset_rs1_fwd", ex_rs1_fwd, 32'h0);
    check("reset_rs2_fwd", ex_rs2_fwd, 32'h0);
    check("reset_bubbles", 32'(bubble_count), 32'h0);
    tick();
    rst_n = 1;

    // forwarding priority
    id_valid = 1; id_pc = 32'h10; id_rs1 = 5; id_rs1_data = 32'h100;
    id_rs2 = 0; id_rs2_data = 32'h200; id_rd = 3; id_reg_write = 1; id_imm32 = 32'hFFFF_FFF0;
    tick();
    idle_inputs();
    #1;
    check("cap_valid", 32'(ex_valid), 32'h1);
    check("cap_pc", ex_pc, 32'h10);
    check("cap_rd", 32'(ex_rd), 32'h3);
    check("cap_imm", ex_imm32, 32'hFFFF_FFF0);
    check("cap_regwr", 32'(ex_reg_write), 32'h1);
    mem_rd = 5; mem_reg_write = 1; mem_result = 32'h11;
    wb_rd = 5; wb_reg_write = 1; wb_data = 32'h22;
    #1;
    check("fwd_mem_prio", ex_rs1_fwd, 32'h11);
    mem_reg_write = 0;
    #1;
    check("fwd_wb", ex_rs1_fwd, 32'h22);
    wb_reg_write = 0;
    #1;
    check("fwd_none", ex_rs1_fwd, 32'h100);

    // x0 guard
    mem_rd = 0; mem_reg_write = 1; mem_result = 32'hDEAD;
    wb_rd = 0; wb_reg_write = 1; wb_data = 32'hBEEF;
    #1;
    check("x0_guard", ex_rs2_fwd, 32'h200);
    idle_inputs();

    // load-use stall
    load_lw_x7();
    tick();
    check("lw_in_ex", 32'(ex_mem_read), 32'h1);
    add_x8_x7_x1();
    #1;
    check("luh_stall", 32'(stall_id), 32'h1);
    tick();
    check("luh_bubble_valid", 32'(ex_valid), 32'h0);
    check("luh_bubble_regwr", 32'(ex_reg_write), 32'h0);
    check("luh_count", 32'(bubble_count), 32'h1);
    check("luh_stall_clear", 32'(stall_id), 32'h0);
    tick();
    check("add_valid", 32'(ex_valid), 32'h1);
    check("add_rd", 32'(ex_rd), 32'h8);
    check("add_count", 32'(bubble_count), 32'h1);
    wb_rd = 7; wb_reg_write = 1; wb_data = 32'h777;
    #1;
    check("add_fwd_load", ex_rs1_fwd, 32'h777);
    check("add_rs2", ex_rs2_fwd, 32'h10);

    // flush over stall
    load_lw_x7();
    tick();
    add_x8_x7_x1();
    flush = 1;
    #1;
    check("flush_stall", 32'(stall_id), 32'h0);
    tick();
    check("flush_valid", 32'(ex_valid), 32'h0);
    check("flush_memrd", 32'(ex_mem_read), 32'h0);
    check("flush_count", 32'(bubble_count), 32'h1);

    // hold freezes EX, and masks a load-use hazard
    idle_inputs();
    id_valid = 1; id_pc = 32'h40; id_rd = 4; id_rs1 = 3; id_rs1_data = 32'h333;
    id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
    tick();
    check("pre_hold_pc", ex_pc, 32'h40);
    idle_inputs();
    hold = 1;
    id_valid = 1; id_pc = 32'h80; id_rd = 9; id_rs1 = 4; id_use_rs1 = 1; id_reg_write = 1;
    #1;
    check("hold_stall", 32'(stall_id), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_pc", ex_pc, 32'h40);
      check("hold_rd", 32'(ex_rd), 32'h4);
      check("hold_valid", 32'(ex_valid), 32'h1);
    end
    check("hold_count", 32'(bubble_count), 32'h1);

    // capture bypass from write-back
    idle_inputs();
    id_valid = 1; id_pc = 32'h84; id_rd = 10; id_rs1 = 9; id_use_rs1 = 1; id_rs1_data = 32'h0;
    id_reg_write = 1;
    wb_rd = 9; wb_reg_write = 1; wb_data = 32'h55;
    tick();
    idle_inputs();
    #1;
    check("bypass_capture", ex_rs1_fwd, 32'h55);
    check("bypass_pc", ex_pc, 32'h84);

    // asynchronous reset mid-cycle
    #2;
    rst_n = 0;
    #1;
    check("async_valid", 32'(ex_valid), 32'h0);
    check("async_pc", ex_pc, 32'h0);
    check("async_regwr", 32'(ex_reg_write), 32'h0);
    check("async_rs1_fwd", ex_rs1_fwd, 32'h0);
    check("async_count", 32'(bubble_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
